// File: rtl/mrs_pkg.sv
// Shared types for the range streamer: FSM state encoding and walk direction.
package mrs_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/mrs_word_ram.sv
// DATA_W x DEPTH word array: synchronous write, combinational read, contents never reset.
module mrs_word_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_addr,
   output logic [DATA_W-1:0]          rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/mem_range_streamer.sv
// Streams an inclusive address range of a word RAM over valid/ready, ascending or descending.
// First out_valid two cycles after start, one word per two cycles; out_data/out_addr hold while out_ready is low.
module mem_range_streamer
   import mrs_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       start,
   input  logic [$clog2(DEPTH)-1:0]   start_addr,
   input  logic [$clog2(DEPTH)-1:0]   end_addr,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH)-1:0]   out_addr
);

   localparam int ADDR_W = $clog2(DEPTH);
   // One extra bit so a power-of-two DEPTH is representable for the range compare.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_cur;
   logic [ADDR_W-1:0]   r_end;
   logic                r_dir;
   logic [DATA_W-1:0]   r_out_data;
   logic [ADDR_W-1:0]   r_out_addr;
   logic                r_done;
   logic                r_err;

   logic                w_idle;
   logic                w_wr_addr_ok;
   logic                w_sa_ok;
   logic                w_ea_ok;
   logic                w_wr_ok;
   logic                w_start_ok;
   logic                w_req_err;
   logic                w_hs;
   logic                w_last;
   logic [DATA_W-1:0]   w_rd_data;

   assign w_idle       = (r_state == IDLE);
   assign w_wr_addr_ok = ({1'b0, wr_addr}    < DEPTH_L);
   assign w_sa_ok      = ({1'b0, start_addr} < DEPTH_L);
   assign w_ea_ok      = ({1'b0, end_addr}   < DEPTH_L);

   assign w_wr_ok    = wr_en && w_idle && w_wr_addr_ok;
   assign w_start_ok = start && w_idle && w_sa_ok && w_ea_ok;
   // A start arriving while busy is silently ignored; only idle starts can be rejected.
   assign w_req_err  = (wr_en && !(w_idle && w_wr_addr_ok)) ||
                       (start && w_idle && !(w_sa_ok && w_ea_ok));

   assign w_hs   = (r_state == SEND) && out_ready;
   assign w_last = w_hs && (r_cur == r_end);

   mrs_word_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (w_wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (r_cur),
      .rd_data (w_rd_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_start_ok) w_state_nxt = FETCH;
         FETCH:   w_state_nxt = SEND;
         SEND:    if (w_last) w_state_nxt = IDLE;
                  else if (w_hs) w_state_nxt = FETCH;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != IDLE);
      out_valid = (r_state == SEND);
      done      = r_done;
      err       = r_err;
      out_data  = r_out_data;
      out_addr  = r_out_addr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cur      <= '0;
         r_end      <= '0;
         r_dir      <= DIR_UP;
         r_out_data <= '0;
         r_out_addr <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= w_last;
         r_err  <= w_req_err;
         if (w_start_ok) begin
            r_cur <= start_addr;
            r_end <= end_addr;
            r_dir <= (start_addr > end_addr) ? DIR_DOWN : DIR_UP;
         end
         if (r_state == FETCH) begin
            r_out_data <= w_rd_data;
            r_out_addr <= r_cur;
         end
         // The range was validated at start, so stepping toward r_end never wraps.
         if (w_hs && !w_last) begin
            r_cur <= (r_dir == DIR_DOWN) ? r_cur - ADDR_W'(1) : r_cur + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_range_streamer.sv
// Bench for mem_range_streamer: directed scenarios plus randomized traffic against a word-queue model.
module tb_mem_range_streamer;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 6;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] start_addr = '0;
   logic [ADDR_W-1:0] end_addr = '0;
   logic              busy, done, err, out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;

   mem_range_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .start_addr(start_addr), .end_addr(end_addr),
      .busy(busy), .done(done), .err(err), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   // Model: the pending words of the current stream, and the cycles until the head becomes valid.
   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      bit                known;
   } wd_t;

   wd_t               mq[$];
   int                gap = 0;
   bit                m_done = 1'b0;
   bit                m_err = 1'b0;
   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_known [DEPTH];

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         m_known[i] = 1'b0;
         m_mem[i]   = '0;
      end
   end

   always @(posedge clk) begin
      bit idle, hs;
      int s, e, st;
      idle = (mq.size() == 0);
      hs   = !idle && (gap == 0) && out_ready;
      if (!rst_n) begin
         mq.delete();
         gap    = 0;
         m_done = 1'b0;
         m_err  = 1'b0;
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         if (wr_en) begin
            if (idle && int'(wr_addr) < DEPTH) begin
               m_mem[wr_addr]   = wr_data;
               m_known[wr_addr] = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end
         if (hs) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_done = 1'b1;
            else gap = 1;
         end else if (gap > 0) begin
            gap--;
         end
         if (start && idle) begin
            s = int'(start_addr);
            e = int'(end_addr);
            if (s < DEPTH && e < DEPTH) begin
               st = (s <= e) ? 1 : -1;
               for (int a = s; a != e + st; a += st) begin
                  wd_t w;
                  w.a     = ADDR_W'(a);
                  w.d     = m_mem[a];
                  w.known = m_known[a];
                  mq.push_back(w);
               end
               gap = 1;
            end else begin
               m_err = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      bit ev;
      if (chk_en) begin
         ev = (mq.size() > 0) && (gap == 0);
         chk("busy", busy, mq.size() > 0);
         chk("out_valid", out_valid, ev);
         chk("done", done, m_done);
         chk("err", err, m_err);
         chk("done_valid_excl", done & out_valid, 0);
         if (ev) begin
            chk("out_addr", out_addr, mq[0].a);
            if (mq[0].known) chk("out_data", out_data, mq[0].d);
         end
      end
   end

   logic [ADDR_W-1:0] cap_a[$];
   logic [DATA_W-1:0] cap_d[$];
   int                n_done = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            cap_a.push_back(out_addr);
            cap_d.push_back(out_data);
         end
         if (done) n_done++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic go(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
      start = 1'b1; start_addr = s; end_addr = e;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_cap();
      cap_a.delete();
      cap_d.delete();
      n_done = 0;
   endtask

   task automatic wait_idle(string n);
      for (int i = 0; i < 200 && busy; i++) tick();
      chk({n, "_timeout"}, busy, 0);
      tick();
   endtask

   logic [DATA_W-1:0] ld [4];

   initial begin
      ld[0] = 16'h1234; ld[1] = 16'h5678; ld[2] = 16'h9ABC; ld[3] = 16'hDEF0;

      rst_n = 1'b0;
      tick();
      chk_en = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_addr", out_addr, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Ascending full range
      for (int i = 0; i < 4; i++) wr(ADDR_W'(i), ld[i]);
      out_ready = 1'b1;
      clear_cap();
      go(3'd0, 3'd3);
      wait_idle("up");
      chk("up_count", cap_a.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("up_data", cap_d[i], ld[i]);
         chk("up_addr", cap_a[i], i);
      end
      chk("up_done_cnt", n_done, 1);
      chk("up_busy_after", busy, 0);

      // Descending 3->1, with an ignored start while busy
      clear_cap();
      go(3'd3, 3'd1);
      go(3'd0, 3'd0);
      chk("busy_start_no_err", err, 0);
      wait_idle("down");
      chk("down_count", cap_a.size(), 3);
      chk("down_d0", cap_d[0], 16'hDEF0);
      chk("down_a0", cap_a[0], 3);
      chk("down_d1", cap_d[1], 16'h9ABC);
      chk("down_a1", cap_a[1], 2);
      chk("down_d2", cap_d[2], 16'h5678);
      chk("down_a2", cap_a[2], 1);
      chk("down_done_cnt", n_done, 1);

      // Single word with backpressure
      clear_cap();
      out_ready = 1'b0;
      go(3'd2, 3'd2);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, 16'h9ABC);
         chk("stall_addr", out_addr, 2);
         tick();
      end
      out_ready = 1'b1;
      wait_idle("single");
      chk("single_count", cap_a.size(), 1);
      chk("single_data", cap_d[0], 16'h9ABC);
      chk("single_done_cnt", n_done, 1);

      // Write while busy is dropped; out-of-range start is rejected
      go(3'd0, 3'd3);
      wr(3'd1, 16'hBEEF);
      chk("busy_wr_err", err, 1);
      wait_idle("busywr");
      clear_cap();
      go(3'd1, 3'd1);
      wait_idle("reread");
      chk("reread_data", cap_d[0], 16'h5678);
      go(3'd7, 3'd0);
      chk("bad_start_err", err, 1);
      chk("bad_start_busy", busy, 0);
      tick();
      chk("err_one_cycle", err, 0);
      wr(3'd6, 16'h1111);
      chk("bad_wr_err", err, 1);
      tick();

      // Reset during SEND of the second word
      clear_cap();
      go(3'd0, 3'd3);
      for (int i = 0; i < 50 && !(out_valid && out_addr == 3'd1); i++) tick();
      chk("mid_reach", out_valid && out_addr == 3'd1, 1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      rst_n = 1'b1;
      n_done = 0;
      tick();
      tick();
      chk("mid_rst_no_done", n_done, 0);
      clear_cap();
      go(3'd0, 3'd0);
      wait_idle("retain");
      chk("retain_data", cap_d[0], 16'h1234);

      // Never-written words: protocol and done timing only
      clear_cap();
      go(3'd4, 3'd5);
      wait_idle("unwritten");
      chk("unwr_count", cap_a.size(), 2);
      chk("unwr_a0", cap_a[0], 4);
      chk("unwr_a1", cap_a[1], 5);
      chk("unwr_done_cnt", n_done, 1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         out_ready  = ($urandom_range(0, 3) != 0);
         wr_en      = ($urandom_range(0, 7) == 0);
         wr_addr    = ADDR_W'($urandom_range(0, 7));
         wr_data    = DATA_W'($urandom);
         start      = ($urandom_range(0, 5) == 0);
         start_addr = ADDR_W'($urandom_range(0, 7));
         end_addr   = ADDR_W'($urandom_range(0, 7));
         rst_n      = ($urandom_range(0, 199) != 0);
         tick();
      end
      wr_en = 1'b0;
      start = 1'b0;
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      wait_idle("rand_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_range_streamer.md
Name: mem_range_streamer

Overview:
- Word memory (DATA_W x DEPTH) loaded through a simple write port, then streamed out over a valid/ready interface.
- Streams an inclusive address range, ascending or descending, with the same range semantics as $readmemh start/end: start_addr > end_addr walks downward.
- Sits downstream of the memory-image load path and feeds word consumers (display/checker stages).

Parameters:
- DATA_W, 16, word width.
- DEPTH, 4, number of words; must be >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write strobe, sampled on clk.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- start  in  1  start-stream request, single-cycle pulse.
- start_addr  in  ADDR_W  first address streamed, sampled with start.
- end_addr  in  ADDR_W  last address streamed (inclusive), sampled with start.
- busy  out  1  high from the cycle after an accepted start until the last word handshakes.
- done  out  1  one-cycle pulse in the cycle after the last word handshakes.
- err  out  1  one-cycle pulse flagging a rejected request.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  streamed word.
- out_addr  out  ADDR_W  address of out_data.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State -> IDLE.
  - busy, done, err, out_valid = 0; out_data, out_addr = 0.
  - Memory contents are NOT reset. Unwritten words read X.
- Reset mid-stream: abort immediately and return to IDLE. No done pulse; memory retained.
- Writes:
  - Accepted only in IDLE: mem[wr_addr] <= wr_data.
  - wr_en while busy: write dropped, err pulses.
  - wr_addr >= DEPTH: write dropped, err pulses.
- FSM states: IDLE, FETCH, SEND.
- IDLE:
  - start with start_addr and end_addr both < DEPTH: latch cur=start_addr, end=end_addr, dir=down if start_addr > end_addr; go to FETCH; busy=1.
  - start with either address >= DEPTH: err pulses, stay in IDLE.
  - start and wr_en in the same cycle: the write is performed first, and the stream sees the new data.
- FETCH (1 cycle): out_data <= mem[cur]; out_addr <= cur; go to SEND.
- SEND:
  - out_valid=1. out_data and out_addr are held stable until out_valid && out_ready.
  - On handshake with cur==end: go to IDLE, busy=0, done=1 next cycle.
  - On handshake otherwise: cur <= cur+1 (up) or cur-1 (down), go to FETCH.
- Throughput and latency:
  - Max throughput is 1 word per 2 cycles.
  - Latency from start to first out_valid is 2 cycles.
- start_addr == end_addr: exactly one word is streamed.
- start while busy: ignored (no err). The stream continues unchanged.
- cur never wraps, because the range is inclusive and checked at start.
- out_valid deasserts in the cycle after the final handshake. done and out_valid are never high together.

Decomposition:
- Shared package mrs_pkg holds:
  - state enum: IDLE, FETCH, SEND.
  - direction constants: DIR_UP, DIR_DOWN.
- One natural sub-module: mrs_word_ram, a DATA_W x DEPTH array with a synchronous write port and a combinational read port. The FSM registers the read result in FETCH.

Test Plan:
- Load 1234, 5678, 9ABC, DEF0 at addresses 0..3; start 0->3 with out_ready=1 -> words 1234, 5678, 9ABC, DEF0 with out_addr 0..3; done pulses once; busy low after.
- Same load; start 3->1 -> DEF0 (addr 3), 9ABC (addr 2), 5678 (addr 1); then done; address 0 never output.
- start 2->2 -> single word 9ABC at addr 2, then done; out_ready held low 5 cycles -> out_valid and out_data stable at 9ABC throughout.
- Write to address 1 while busy -> err pulse; a following stream 1->1 still returns 5678. start with start_addr >= DEPTH (DEPTH=6, ADDR_W=3, start_addr=7) -> err pulse, busy stays 0.
- rst_n=0 during SEND of the second word of a 0->3 stream -> next cycle out_valid=0, busy=0, no done. A new stream 0->0 then returns 1234, proving memory is retained.
- Stream 0->1 on a fresh reset without writes -> out_data X for both words; handshake protocol and done timing are unaffected.
